// File: rtl/mem_image_sequencer.sv
// mem_image_sequencer
//   Drives one memory channel through a load / run / check sequence:
//   streams DEPTH words from an image source into the target memory's
//   external write port, enables the cpu until it reaches the STOP opcode
//   or the cycle limit, then reads back a result window and compares it
//   word by word against a reference port.
//
// Ports
//   clk_i, rst_i       clock (rising edge), synchronous active-high reset
//   start_i            one-cycle start pulse, honoured in IDLE or DONE only
//   src_addr_o/src_rdata_i   image source word index / data (1-cycle latency)
//   ref_addr_o/ref_rdata_i   reference word index / data (1-cycle latency)
//   mem_addr_o         target byte address (word index << STRIDE_LOG2)
//   mem_wen_o/mem_ren_o/mem_wdata_o/mem_rdata_i  target memory port
//   instr_i            cpu current instruction
//   cpu_enable_o       cpu run enable
//   done_o, pass_o, timed_out_o, test_id_o, cycle_cnt_o, err_cnt_o,
//   first_err_idx_o    sequence status and results
module mem_image_sequencer #(
   parameter int         DATA_W      = 64,
   parameter int         ADDR_W      = 64,
   parameter int         DEPTH       = 128,
   parameter int         STRIDE_LOG2 = 3,
   parameter int         CHECK_BASE  = 50,
   parameter int         CHECK_N     = 24,
   parameter int         TIMEOUT     = 99999,
   parameter logic [6:0] STOP_OPC    = 7'b1111110,
   parameter bit         RUN_EN      = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic [ADDR_W-1:0] src_addr_o,
   input  logic [DATA_W-1:0] src_rdata_i,
   output logic [ADDR_W-1:0] ref_addr_o,
   input  logic [DATA_W-1:0] ref_rdata_i,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_wen_o,
   output logic              mem_ren_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic [31:0]       instr_i,
   output logic              cpu_enable_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timed_out_o,
   output logic [3:0]        test_id_o,
   output logic [31:0]       cycle_cnt_o,
   output logic [15:0]       err_cnt_o,
   output logic [15:0]       first_err_idx_o
);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

   localparam logic [31:0] DEPTH_C    = 32'(DEPTH);
   localparam logic [31:0] CHECK_N_C  = 32'(CHECK_N);
   localparam logic [31:0] TIMEOUT_C  = 32'(TIMEOUT);
   localparam state_t      AFTER_RUN  = (CHECK_N != 0) ? S_CHECK : S_DONE;
   localparam state_t      AFTER_LOAD = RUN_EN ? S_RUN : AFTER_RUN;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              wr_vld_q, wr_vld_d;
   logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
   logic              rd_vld_q, rd_vld_d;
   logic [15:0]       rd_idx_q, rd_idx_d;
   logic [31:0]       cycle_cnt_q, cycle_cnt_d;
   logic              timed_out_q, timed_out_d;
   logic [3:0]        test_id_q, test_id_d;
   logic [15:0]       err_cnt_q, err_cnt_d;
   logic [15:0]       first_err_idx_q, first_err_idx_d;
   logic [ADDR_W-1:0] chk_word;

   // Only the opcode and the test id field of the instruction matter here.
   logic unused_instr;
   assign unused_instr = ^instr_i[27:7];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= S_IDLE;
         cnt_q           <= '0;
         wr_vld_q        <= 1'b0;
         rd_vld_q        <= 1'b0;
         cycle_cnt_q     <= '0;
         timed_out_q     <= 1'b0;
         test_id_q       <= '0;
         err_cnt_q       <= '0;
         first_err_idx_q <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wr_vld_q        <= wr_vld_d;
         rd_vld_q        <= rd_vld_d;
         cycle_cnt_q     <= cycle_cnt_d;
         timed_out_q     <= timed_out_d;
         test_id_q       <= test_id_d;
         err_cnt_q       <= err_cnt_d;
         first_err_idx_q <= first_err_idx_d;
      end
   end

   // Indices ride along with their valid flags; only the flags need reset.
   always_ff @(posedge clk_i) begin
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      wr_vld_d        = 1'b0;
      wr_idx_d        = wr_idx_q;
      rd_vld_d        = 1'b0;
      rd_idx_d        = rd_idx_q;
      cycle_cnt_d     = cycle_cnt_q;
      timed_out_d     = timed_out_q;
      test_id_d       = test_id_q;
      err_cnt_d       = err_cnt_q;
      first_err_idx_d = first_err_idx_q;
      src_addr_o      = '0;
      ref_addr_o      = '0;
      mem_ren_o       = 1'b0;
      cpu_enable_o    = 1'b0;
      chk_word        = '0;

      // Compare stage: read data and reference word arrive one cycle after
      // the read was issued.
      if (rd_vld_q && (mem_rdata_i != ref_rdata_i)) begin
         err_cnt_d = sat_inc16(err_cnt_q);
         if (err_cnt_q == 16'd0) first_err_idx_d = rd_idx_q;
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               state_d         = S_LOAD;
               cnt_d           = '0;
               cycle_cnt_d     = '0;
               timed_out_d     = 1'b0;
               test_id_d       = '0;
               err_cnt_d       = '0;
               first_err_idx_d = '0;
            end
         end
         S_LOAD: begin
            if (cnt_q < DEPTH_C) begin
               src_addr_o = ADDR_W'(cnt_q);
               wr_vld_d   = 1'b1;
               wr_idx_d   = ADDR_W'(cnt_q);
               cnt_d      = cnt_q + 32'd1;
            end else begin
               // The final write is on the bus this cycle.
               cnt_d   = '0;
               state_d = AFTER_LOAD;
            end
         end
         S_RUN: begin
            cpu_enable_o = 1'b1;
            cycle_cnt_d  = cycle_cnt_q + 32'd1;
            // STOP is tested first so it wins over a simultaneous timeout.
            if (instr_i[6:0] == STOP_OPC) begin
               test_id_d = instr_i[31:28];
               state_d   = AFTER_RUN;
            end else if (cycle_cnt_d == TIMEOUT_C) begin
               timed_out_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_CHECK: begin
            if (cnt_q < CHECK_N_C) begin
               mem_ren_o  = 1'b1;
               ref_addr_o = ADDR_W'(cnt_q);
               chk_word   = ADDR_W'(CHECK_BASE) + ADDR_W'(cnt_q);
               rd_vld_d   = 1'b1;
               rd_idx_d   = cnt_q[15:0];
               cnt_d      = cnt_q + 32'd1;
            end else begin
               // The last compare is resolved this cycle.
               cnt_d   = '0;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      mem_addr_o = '0;
      if (wr_vld_q)       mem_addr_o = wr_idx_q << STRIDE_LOG2;
      else if (mem_ren_o) mem_addr_o = chk_word << STRIDE_LOG2;
   end

   // Write stage: source data is one cycle behind its address.
   assign mem_wen_o       = wr_vld_q;
   assign mem_wdata_o     = wr_vld_q ? src_rdata_i : '0;
   assign done_o          = (state_q == S_DONE);
   assign pass_o          = done_o && !timed_out_q && (err_cnt_q == 16'd0);
   assign timed_out_o     = timed_out_q;
   assign test_id_o       = test_id_q;
   assign cycle_cnt_o     = cycle_cnt_q;
   assign err_cnt_o       = err_cnt_q;
   assign first_err_idx_o = first_err_idx_q;

endmodule

// File: tb/tb_mem_image_sequencer.sv
module tb_mem_image_sequencer;
   localparam int         DATA_W      = 32;
   localparam int         ADDR_W      = 16;
   localparam int         DEPTH       = 64;
   localparam int         STRIDE_LOG2 = 3;
   localparam int         CHECK_BASE  = 50;
   localparam int         CHECK_N     = 24;
   localparam int         TIMEOUT     = 100;
   localparam logic [6:0] STOP_OPC    = 7'b1111110;
   localparam int         MEM_WORDS   = 256;

   logic              clk = 1'b0;
   logic              rst, start, mem_init;
   logic [ADDR_W-1:0] src_addr, ref_addr, mem_addr;
   logic [DATA_W-1:0] src_rdata, ref_rdata, mem_rdata, mem_wdata;
   logic              mem_wen, mem_ren, cpu_enable, done, pass, timed_out;
   logic [31:0]       instr, cycle_cnt;
   logic [3:0]        test_id;
   logic [15:0]       err_cnt, first_err_idx;

   always #5 clk = ~clk;

   mem_image_sequencer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STRIDE_LOG2(STRIDE_LOG2),
      .CHECK_BASE(CHECK_BASE), .CHECK_N(CHECK_N), .TIMEOUT(TIMEOUT),
      .STOP_OPC(STOP_OPC), .RUN_EN(1'b1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .src_addr_o(src_addr), .src_rdata_i(src_rdata),
      .ref_addr_o(ref_addr), .ref_rdata_i(ref_rdata),
      .mem_addr_o(mem_addr), .mem_wen_o(mem_wen), .mem_ren_o(mem_ren),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
      .instr_i(instr), .cpu_enable_o(cpu_enable),
      .done_o(done), .pass_o(pass), .timed_out_o(timed_out),
      .test_id_o(test_id), .cycle_cnt_o(cycle_cnt),
      .err_cnt_o(err_cnt), .first_err_idx_o(first_err_idx)
   );

   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [DATA_W-1:0] init_pat(input int i);
      return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30000;
   endfunction

   function automatic logic [31:0] nonstop_instr();
      logic [31:0] v;
      v = $urandom;
      if (v[6:0] == STOP_OPC) v[0] = ~v[0];
      return v;
   endfunction

   // Environment: image source, reference and target memory
   logic [DATA_W-1:0] src_arr   [DEPTH];
   logic [DATA_W-1:0] ref_arr   [CHECK_N];
   logic [DATA_W-1:0] tmem      [MEM_WORDS];
   logic [DATA_W-1:0] model_mem [MEM_WORDS];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_WORDS; i++) tmem[i] <= init_pat(i);
      end else if (mem_wen) begin
         tmem[mem_addr[STRIDE_LOG2+7:STRIDE_LOG2]] <= mem_wdata;
      end
      mem_rdata <= tmem[mem_addr[STRIDE_LOG2+7:STRIDE_LOG2]];
      src_rdata <= src_arr[src_addr[5:0]];
      ref_rdata <= (ref_addr < ADDR_W'(CHECK_N)) ? ref_arr[ref_addr[4:0]] : '0;
   end

   // Scoreboard queues
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_t;
   typedef struct packed {
      logic        to;
      logic [3:0]  tid;
      logic [31:0] cyc;
      logic [15:0] err;
      logic [15:0] first;
      logic        pass;
   } res_t;
   wr_t               exp_wr_q[$];
   logic [ADDR_W-1:0] exp_rd_q[$];
   res_t              exp_res_q[$];

   // CPU stand-in: presents STOP on the planned RUN cycle
   int         stop_at = 0;
   logic [3:0] tid_cur = '0;
   initial begin
      int run_k;
      run_k = 0;
      instr = '0;
      forever begin
         @(negedge clk);
         if (cpu_enable) begin
            run_k++;
            if (run_k == stop_at) instr = {tid_cur, 21'($urandom), STOP_OPC};
            else instr = nonstop_instr();
         end else begin
            run_k = 0;
            instr = nonstop_instr();
         end
      end
   end

   // Monitor
   initial begin
      logic done_prev;
      int   run_len;
      wr_t  w;
      res_t r;
      logic [ADDR_W-1:0] ra;
      done_prev = 1'b0;
      run_len = 0;
      forever begin
         @(negedge clk);
         if (mem_wen || mem_ren) check("wen_ren_exclusive", 64'(mem_wen & mem_ren), 64'd0);
         if (mem_wen) begin
            if (exp_wr_q.size() == 0) check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF);
            else begin
               w = exp_wr_q.pop_front();
               check("wr_addr", 64'(mem_addr), 64'(w.addr));
               check("wr_data", 64'(mem_wdata), 64'(w.data));
            end
         end
         if (mem_ren) begin
            if (exp_rd_q.size() == 0) check("unexpected_read", 64'(mem_addr), 64'hFFFF_FFFF);
            else begin
               ra = exp_rd_q.pop_front();
               check("rd_addr", 64'(mem_addr), 64'(ra));
            end
         end
         if (cpu_enable) run_len++;
         if (done && !done_prev) begin
            if (exp_res_q.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
               r = exp_res_q.pop_front();
               check("timed_out", 64'(timed_out), 64'(r.to));
               check("test_id", 64'(test_id), 64'(r.tid));
               check("cycle_cnt", 64'(cycle_cnt), 64'(r.cyc));
               check("run_cycles", 64'(run_len), 64'(r.cyc));
               check("err_cnt", 64'(err_cnt), 64'(r.err));
               if (r.err != 16'd0) check("first_err_idx", 64'(first_err_idx), 64'(r.first));
               check("pass", 64'(pass), 64'(r.pass));
            end
            run_len = 0;
         end
         done_prev = done;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic end_sim();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_src_addr"}, 64'(src_addr), 64'd0);
      check({tag, "_ref_addr"}, 64'(ref_addr), 64'd0);
      check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
      check({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
      check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
      check({tag, "_cpu_enable"}, 64'(cpu_enable), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_pass"}, 64'(pass), 64'd0);
      check({tag, "_timed_out"}, 64'(timed_out), 64'd0);
      check({tag, "_test_id"}, 64'(test_id), 64'd0);
      check({tag, "_cycle_cnt"}, 64'(cycle_cnt), 64'd0);
      check({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
      check({tag, "_first_err_idx"}, 64'(first_err_idx), 64'd0);
   endtask

   // One full sequence: plan the expected image, writes, reads and result,
   // then start the DUT and wait for done.
   task automatic run_txn(input int stop, input logic [3:0] tid,
                          input logic [CHECK_N-1:0] flips, input bit poke_run);
      res_t r;
      bit   ran, ok;
      int   err, first;
      for (int i = 0; i < DEPTH; i++) begin
         src_arr[i]   = $urandom;
         model_mem[i] = src_arr[i];
         exp_wr_q.push_back('{addr: ADDR_W'(i << STRIDE_LOG2), data: src_arr[i]});
      end
      for (int j = 0; j < CHECK_N; j++)
         ref_arr[j] = model_mem[CHECK_BASE + j] ^ (flips[j] ? DATA_W'($urandom | 32'd1) : '0);
      ran = (stop >= 1) && (stop <= TIMEOUT);
      err = 0;
      first = 0;
      if (ran) begin
         for (int j = 0; j < CHECK_N; j++) begin
            exp_rd_q.push_back(ADDR_W'((CHECK_BASE + j) << STRIDE_LOG2));
            if (model_mem[CHECK_BASE + j] != ref_arr[j]) begin
               if (err == 0) first = j;
               err++;
            end
         end
      end
      r.to    = !ran;
      r.tid   = ran ? tid : 4'd0;
      r.cyc   = ran ? 32'(stop) : 32'(TIMEOUT);
      r.err   = 16'(err);
      r.first = 16'(first);
      r.pass  = ran && (err == 0);
      exp_res_q.push_back(r);
      stop_at = stop;
      tid_cur = tid;

      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_clears_done", 64'(done), 64'd0);
      check("start_clears_timed_out", 64'(timed_out), 64'd0);
      check("start_clears_err_cnt", 64'(err_cnt), 64'd0);
      check("start_clears_cycle_cnt", 64'(cycle_cnt), 64'd0);
      check("start_clears_test_id", 64'(test_id), 64'd0);

      if (poke_run) begin
         for (int c = 0; c < DEPTH + 20 && !cpu_enable; c++) tick();
         start = 1'b1;
         tick();
         start = 1'b0;
      end

      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         check("done_wait_expired", 64'd0, 64'd1);
         end_sim();
         forever tick();
      end
      tick(3);
      check("done_held", 64'(done), 64'd1);
      check("pass_held", 64'(pass), 64'(r.pass));
   endtask

   initial begin
      logic [CHECK_N-1:0] flips;
      int s;
      rst = 1'b1;
      start = 1'b0;
      mem_init = 1'b1;
      for (int i = 0; i < MEM_WORDS; i++) model_mem[i] = init_pat(i);
      for (int j = 0; j < CHECK_N; j++) ref_arr[j] = '0;
      for (int i = 0; i < DEPTH; i++) src_arr[i] = '0;
      tick(3);
      rst = 1'b0;
      mem_init = 1'b0;
      tick();
      check_all_zero("reset");

      // STOP on RUN cycle 37 with test id 4; start pulsed during RUN
      run_txn(37, 4'd4, '0, 1'b1);
      // no STOP: timeout after TIMEOUT cycles, CHECK skipped
      run_txn(0, 4'd0, '0, 1'b0);
      // STOP on the timeout cycle: STOP wins, CHECK runs
      run_txn(TIMEOUT, 4'd9, '0, 1'b0);
      // window words 54 and 60 disagree with the reference
      flips = '0;
      flips[54 - CHECK_BASE] = 1'b1;
      flips[60 - CHECK_BASE] = 1'b1;
      run_txn(20, 4'd2, flips, 1'b0);

      // reset in the middle of LOAD while word 2 is being addressed
      for (int i = 0; i < DEPTH; i++) src_arr[i] = $urandom;
      for (int i = 0; i < 2; i++) begin
         model_mem[i] = src_arr[i];
         exp_wr_q.push_back('{addr: ADDR_W'(i << STRIDE_LOG2), data: src_arr[i]});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(2);
      check("abort_src_addr", 64'(src_addr), 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("abort");
      check("abort_writes_seen", 64'(exp_wr_q.size()), 64'd0);
      tick(2);
      run_txn(5, 4'd7, '0, 1'b0);

      for (int t = 0; t < 10; t++) begin
         s = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 110));
         for (int j = 0; j < CHECK_N; j++) flips[j] = ($urandom_range(0, 7) == 0);
         run_txn(s, 4'($urandom), flips, 1'($urandom_range(0, 1)));
      end

      check("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
      check("reads_outstanding", 64'(exp_rd_q.size()), 64'd0);
      check("results_outstanding", 64'(exp_res_q.size()), 64'd0);
      end_sim();
   end

endmodule
